// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing with a one-entry output register and ready/valid handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       serial_in_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;

    function automatic logic f_even_parity_ok(input logic [7:0] d, input logic p);
        return ~(^{d, p});
    endfunction
`endif

    logic [1:0]    r_sync;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic          w_rx_s;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_stop_sample;
    logic          w_par_ok;
    logic          w_good;
    logic [7:0]    w_data_nxt;
    logic          w_valid_nxt;
    logic          w_overrun_nxt;

    assign w_rx_s = r_sync[1];

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], serial_in_i};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic w_par_nxt;
    logic r_parity_err;

    assign w_par_ok = f_even_parity_ok(r_shift, r_par);

    // Parity bit capture and parity error pulse.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par        <= w_par_nxt;
            r_parity_err <= w_stop_sample & w_rx_s & ~w_par_ok;
        end
    end

    assign parity_err_o = r_parity_err;
`else
    assign w_par_ok     = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    // Frame FSM: sampling points sit mid-bit, counted from the half-bit start check.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt     = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = 3'd0;
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_cnt == LP_CNT_HALF) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = w_rx_s;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_cnt_nxt     = '0;
                    w_stop_sample = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    assign w_good = w_stop_sample & w_rx_s & w_par_ok;

    // Output holding register: a consumed slot may be refilled in the same cycle.
    always_comb begin
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = 1'b0;
        if (w_good) begin
            if (r_valid && !ready_i) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_data_nxt  = r_shift;
                w_valid_nxt = 1'b1;
            end
        end else if (r_valid && ready_i) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    // FSM, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_stop_sample & ~w_rx_s;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule
